adc_capture_buf: RTL and testbench

//  Snapshot buffer downstream of the TI-ADC core. Registers the ADC_WAYS parallel sub-ADC words

---
 rtl/adc_capbuf_pkg.sv | 11 +
 rtl/adc_capbuf_trig.sv | 36 +++
 rtl/adc_capture_buf.sv | 142 ++++++++++++++
 tb/tb_adc_capture_buf.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capbuf_pkg.sv
// rtl/adc_capbuf_pkg.sv - shared types for the ADC snapshot capture buffer
package adc_capbuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    READ = 2'd3
  } cap_state_t;

endpackage

// File: rtl/adc_capbuf_trig.sv
// rtl/adc_capbuf_trig.sv - level-crossing detector on one sub-ADC way
// CAPBUF_TRIG_EN selects the real detector; without it trig_hit is tied high.
module adc_capbuf_trig #(
  parameter int ADC_WAYS = 8,
  parameter int ADC_BITS = 9,
  parameter int WW       = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [0:ADC_WAYS-1][ADC_BITS-1:0]   frm,
  input  logic [WW-1:0]                       trig_way,
  input  logic [ADC_BITS-1:0]                 trig_level,
  input  logic                                trig_rise,
  output logic                                trig_hit
);

`ifdef CAPBUF_TRIG_EN
  logic [ADC_BITS-1:0] cur;
  logic [ADC_BITS-1:0] prv;

  assign cur = frm[trig_way];

  always_ff @(posedge clk) begin
    if (rst) prv <= '0;
    else     prv <= cur;
  end

  assign trig_hit = trig_rise ? ((prv <  trig_level) && (cur >= trig_level))
                              : ((prv >= trig_level) && (cur <  trig_level));
`else
  logic unused_trig;
  assign unused_trig = ^{clk, rst, frm, trig_way, trig_level, trig_rise};
  assign trig_hit    = 1'b1;
`endif

endmodule

// File: rtl/adc_capture_buf.sv
// rtl/adc_capture_buf.sv - TI-ADC frame snapshot buffer with pre/post trigger window
// CAPBUF_TRIG_EN enables the level-crossing trigger; otherwise a free-run snapshot.
module adc_capture_buf
  import adc_capbuf_pkg::*;
#(
  parameter  int ADC_WAYS = 8,
  parameter  int ADC_BITS = 9,
  parameter  int DEPTH    = 256,
  localparam int AW       = $clog2(DEPTH),
  localparam int WW       = (ADC_WAYS > 1) ? $clog2(ADC_WAYS) : 1
) (
  input  logic                                adc_coreclk,
  input  logic                                rst,
  input  logic [0:ADC_WAYS-1][ADC_BITS-1:0]   adc_data,
  input  logic                                cap_arm,
  input  logic                                cap_abort,
  input  logic [WW-1:0]                       trig_way,
  input  logic [ADC_BITS-1:0]                 trig_level,
  input  logic                                trig_rise,
  input  logic [AW-1:0]                       pre_len,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [0:ADC_WAYS-1][ADC_BITS-1:0]   rd_data,
  output logic                                rd_last,
  output logic [1:0]                          cap_state,
  output logic                                cap_done
);

`ifdef CAPBUF_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  cap_state_t state;
  logic [0:ADC_WAYS-1][ADC_BITS-1:0] frm;
  logic [0:ADC_WAYS-1][ADC_BITS-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr, trig_ptr, rd_ptr, post_cnt, post_len, read_tp;
  logic [AW:0]   fill, rd_cnt;
  logic          first_frm, trig_hit, trig_ok, go_read;

  adc_capbuf_trig #(
    .ADC_WAYS(ADC_WAYS),
    .ADC_BITS(ADC_BITS),
    .WW      (WW)
  ) u_trig (
    .clk       (adc_coreclk),
    .rst       (rst),
    .frm       (frm),
    .trig_way  (trig_way),
    .trig_level(trig_level),
    .trig_rise (trig_rise),
    .trig_hit  (trig_hit)
  );

  // pre_len is AW bits wide, so it can never exceed DEPTH-1.
  assign post_len = AW'(DEPTH - 1) - pre_len;
  assign trig_ok  = trig_hit && (fill >= {1'b0, pre_len}) && !(TRIG_EN && first_frm);
  assign go_read  = ((state == PRE) && trig_ok && (post_len == '0)) ||
                    ((state == POST) && (post_cnt == AW'(1)));
  assign read_tp  = (state == PRE) ? wr_ptr : trig_ptr;

  always_ff @(posedge adc_coreclk) begin
    if (rst) frm <= '0;
    else     frm <= adc_data;
  end

  always_ff @(posedge adc_coreclk) begin
    if ((state == PRE) || (state == POST)) mem[wr_ptr] <= frm;
  end

  always_ff @(posedge adc_coreclk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      fill      <= '0;
      rd_cnt    <= '0;
      first_frm <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      cap_done  <= 1'b0;
    end else begin
      cap_done <= 1'b0;
      if (cap_abort) begin
        state    <= IDLE;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cap_arm) begin
            state     <= PRE;
            wr_ptr    <= '0;
            fill      <= '0;
            first_frm <= 1'b1;
          end
          PRE: begin
            wr_ptr    <= wr_ptr + AW'(1);
            first_frm <= 1'b0;
            if (fill != (AW+1)'(DEPTH)) fill <= fill + (AW+1)'(1);
            if (trig_ok) begin
              trig_ptr <= wr_ptr;
              post_cnt <= post_len;
              state    <= POST;
            end
          end
          POST: begin
            wr_ptr   <= wr_ptr + AW'(1);
            post_cnt <= post_cnt - AW'(1);
          end
          READ: if (rd_ready) begin
            rd_ptr  <= rd_ptr + AW'(1);
            rd_cnt  <= rd_cnt - (AW+1)'(1);
            rd_last <= (rd_cnt == (AW+1)'(2));
            if (rd_cnt == (AW+1)'(1)) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              cap_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
        // Oldest kept frame sits pre_len slots behind the trigger frame.
        if (go_read) begin
          state    <= READ;
          rd_ptr   <= read_tp - pre_len;
          rd_cnt   <= (AW+1)'(DEPTH);
          rd_valid <= 1'b1;
          rd_last  <= (DEPTH == 1);
        end
      end
    end
  end

  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
  assign cap_state = state;

endmodule

// File: tb/tb_adc_capture_buf.sv
// tb/tb_adc_capture_buf.sv - scoreboard bench for adc_capture_buf (DEPTH=16), CAPBUF_TRIG_EN aware
module tb_adc_capture_buf;

  localparam int WAYS  = 8;
  localparam int BITS  = 9;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int WW    = 3;
  localparam int NFR   = 128;

`ifdef CAPBUF_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  typedef logic [0:WAYS-1][BITS-1:0] frame_t;
  typedef struct packed {
    frame_t data;
    logic   last;
  } exp_t;

  logic            adc_coreclk = 1'b0;
  logic            rst = 1'b1;
  frame_t          adc_data = '0;
  logic            cap_arm = 1'b0;
  logic            cap_abort = 1'b0;
  logic [WW-1:0]   trig_way = '0;
  logic [BITS-1:0] trig_level = '0;
  logic            trig_rise = 1'b1;
  logic [AW-1:0]   pre_len = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  frame_t          rd_data;
  logic            rd_last;
  logic [1:0]      cap_state;
  logic            cap_done;

  int     tests = 0;
  int     fails = 0;
  int     rdy_mode = 0;
  logic   done_pend = 1'b0;
  exp_t   exp_q[$];
  frame_t fr[NFR];

  adc_capture_buf #(.ADC_WAYS(WAYS), .ADC_BITS(BITS), .DEPTH(DEPTH)) dut (
    .adc_coreclk(adc_coreclk),
    .rst        (rst),
    .adc_data   (adc_data),
    .cap_arm    (cap_arm),
    .cap_abort  (cap_abort),
    .trig_way   (trig_way),
    .trig_level (trig_level),
    .trig_rise  (trig_rise),
    .pre_len    (pre_len),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .cap_state  (cap_state),
    .cap_done   (cap_done)
  );

  always #5 adc_coreclk = ~adc_coreclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge adc_coreclk);
    #1;
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int w = 0; w < WAYS; w++) f[w] = BITS'($urandom_range(0, (1 << BITS) - 1));
    return f;
  endfunction

  function automatic logic crossed(frame_t a, frame_t b, int way, logic [BITS-1:0] lvl, logic rise);
    if (rise) return (a[way] < lvl) && (b[way] >= lvl);
    else      return (a[way] >= lvl) && (b[way] < lvl);
  endfunction

  // Frame k written after arm is fr[1+k]; the window is pre_len frames before
  // the first eligible trigger frame plus DEPTH-1-pre_len frames after it.
  task automatic push_expected(input int pl, input int way, input logic [BITS-1:0] lvl,
                               input logic rise, output bit found);
    found = 1'b0;
    for (int k = 0; k <= NFR - 1 - DEPTH && !found; k++) begin
      bit hit;
      hit = TRIG_EN ? (k >= 1 && crossed(fr[k], fr[k+1], way, lvl, rise)) : 1'b1;
      if (hit && k >= pl) begin
        found = 1'b1;
        for (int j = 0; j < DEPTH; j++) exp_q.push_back('{data: fr[1+k-pl+j], last: (j == DEPTH-1)});
      end
    end
  endtask

  task automatic run_cap(input string name, input int pl, input int way,
                         input logic [BITS-1:0] lvl, input logic rise, input int rmode);
    bit found;
    int cnt;
    pre_len    = AW'(pl);
    trig_way   = WW'(way);
    trig_level = lvl;
    trig_rise  = rise;
    rdy_mode   = rmode;
    push_expected(pl, way, lvl, rise, found);
    chk({name, "_model_trig"}, found, 1'b1);
    for (int i = 0; i < NFR; i++) begin
      adc_data = fr[i];
      cap_arm  = (i == 1);
      step();
    end
    cap_arm = 1'b0;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      adc_data = rand_frame();
      step();
      cnt++;
    end
    chk({name, "_frames_left"}, exp_q.size(), 0);
    exp_q.delete();
    step();
    step();
    chk({name, "_idle_after"}, cap_state, 2'd0);
  endtask

  initial begin
    forever begin
      @(posedge adc_coreclk);
      #1;
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks every presented frame (including held frames while stalled)
  // against the head of the scoreboard, and the done pulse timing.
  initial begin
    forever begin
      @(negedge adc_coreclk);
      if (rst) begin
        done_pend = 1'b0;
      end else begin
        chk("cap_done", cap_done, done_pend);
        done_pend = 1'b0;
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            chk("rd_valid_unexpected", rd_valid, 1'b0);
          end else begin
            chk("rd_data", rd_data, exp_q[0].data);
            chk("rd_last", rd_last, exp_q[0].last);
            if (rd_ready) begin
              done_pend = exp_q[0].last;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    bit aborted;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      adc_data = rand_frame();
      step();
    end
    chk("rst_state", cap_state, 2'd0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_last", rd_last, 1'b0);
    chk("rst_done", cap_done, 1'b0);
    rst = 1'b0;
    step();

    // rising ramp on way0 crossing 100
    for (int i = 0; i < NFR; i++) begin
      fr[i] = rand_frame();
      fr[i][0] = BITS'(95 + i);
    end
    run_cap("ramp_rise", 4, 0, 9'd100, 1'b1, 0);
    run_cap("ramp_toggle", 4, 0, 9'd100, 1'b1, 1);

    // abort while in POST
    for (int i = 0; i < NFR; i++) begin
      fr[i] = rand_frame();
      fr[i][0] = BITS'(i);
    end
    pre_len = 4'd2; trig_way = 3'd0; trig_level = 9'd5; trig_rise = 1'b1; rdy_mode = 0;
    aborted = 1'b0;
    for (int i = 0; i < 60; i++) begin
      adc_data  = fr[i];
      cap_arm   = (i == 1);
      cap_abort = !aborted && (cap_state == 2'd2);
      step();
      if (cap_abort) begin
        aborted = 1'b1;
        chk("abort_state", cap_state, 2'd0);
        chk("abort_valid", rd_valid, 1'b0);
        cap_abort = 1'b0;
      end
    end
    cap_arm = 1'b0;
    chk("abort_reached_post", aborted, 1'b1);

    // descending ramp on way3, falling through 50, full pre window
    for (int i = 0; i < NFR; i++) begin
      fr[i] = rand_frame();
      fr[i][3] = BITS'(80 - i);
    end
    run_cap("fall_pre15", 15, 3, 9'd50, 1'b0, 2);

    // ramp starting at 0 on the arm cycle
    for (int i = 0; i < NFR; i++) begin
      fr[i] = rand_frame();
      fr[i][0] = BITS'(i - 1);
    end
    run_cap("ramp_pre3", 3, 0, 9'd10, 1'b1, 0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < NFR; i++) fr[i] = rand_frame();
      run_cap("random", $urandom_range(0, DEPTH-1), $urandom_range(0, WAYS-1),
              BITS'($urandom_range(100, 400)), 1'($urandom_range(0, 1)), 2);
    end

    // reset in the middle of a capture
    pre_len = 4'd0; rdy_mode = 0;
    for (int i = 0; i < 8; i++) begin
      adc_data = rand_frame();
      cap_arm  = (i == 1);
      step();
    end
    cap_arm = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_state", cap_state, 2'd0);
    chk("midrst_valid", rd_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      adc_data = rand_frame();
      step();
    end
    chk("midrst_stays_idle", cap_state, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
